// File: rtl/m_dmem_responder_if.sv
// -----------------------------------------------------------------------------
// m_dmem_responder_if
// Request/response bus between a data-memory initiator and m_dmem_responder.
//
// Request channel (initiator -> responder, valid/ready):
//   w_req_valid  request present          w_req_ready  responder can accept
//   w_req_we     1 = store, 0 = load      w_req_addr   byte address
//   w_req_wd     store data               w_req_be     store byte enables
// Response channel (responder -> initiator, valid/ready):
//   w_rsp_valid  response present         w_rsp_ready  initiator accepts
//   w_rsp_rd     load data (0 otherwise)  w_rsp_err    misaligned / out of range
// -----------------------------------------------------------------------------
interface m_dmem_responder_if;
    logic        w_req_valid;
    logic        w_req_ready;
    logic        w_req_we;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_wd;
    logic [3:0]  w_req_be;
    logic        w_rsp_valid;
    logic        w_rsp_ready;
    logic [31:0] w_rsp_rd;
    logic        w_rsp_err;

    modport master (
        output w_req_valid, w_req_we, w_req_addr, w_req_wd, w_req_be, w_rsp_ready,
        input  w_req_ready, w_rsp_valid, w_rsp_rd, w_rsp_err
    );

    modport slave (
        input  w_req_valid, w_req_we, w_req_addr, w_req_wd, w_req_be, w_rsp_ready,
        output w_req_ready, w_rsp_valid, w_rsp_rd, w_rsp_err
    );
endinterface

// File: rtl/m_dmem_responder.sv
// -----------------------------------------------------------------------------
// m_dmem_responder
// Single-outstanding data-memory responder with a programmable response
// latency. A request is latched when accepted, the block waits LATENCY
// cycles, performs the load/store on the edge that enters RESP and holds the
// registered response until the initiator takes it.
//
// Parameters:
//   LATENCY  extra wait cycles between acceptance and response (0..15)
//   DEPTH    number of 32-bit words, word index taken from addr[7:2]
// Ports:
//   w_clock  clock, rising edge active
//   w_rst_n  synchronous active-low reset
//   bus      m_dmem_responder_if.slave request/response bus
//   w_ncomp  count of completed response handshakes (wraps modulo 2^32)
// -----------------------------------------------------------------------------
module m_dmem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 64
) (
    input  logic                  w_clock,
    input  logic                  w_rst_n,
    m_dmem_responder_if.slave     bus,
    output logic [31:0]           w_ncomp
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [3:0]  r_be;

    logic [31:0] r_rsp_rd;
    logic        r_rsp_err;
    logic [31:0] r_ncomp;

    // Contents start at zero at time zero and are never touched by reset.
    logic [31:0] r_mem [DEPTH] = '{default: 32'h0};

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_rsp_hs;
    logic             w_op_we;
    logic [31:0]      w_op_addr;
    logic [31:0]      w_op_wd;
    logic [3:0]       w_op_be;
    logic             w_op_err;
    logic [IDX_W-1:0] w_op_idx;

    assign w_accept     = bus.w_req_valid && (r_state == IDLE);
    assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);
    assign w_rsp_hs     = (r_state == RESP) && bus.w_rsp_ready;

    // With LATENCY=0 the access happens on the acceptance edge itself, before
    // the request registers hold the new values, so take the live inputs then.
    assign w_op_we   = (r_state == IDLE) ? bus.w_req_we   : r_we;
    assign w_op_addr = (r_state == IDLE) ? bus.w_req_addr : r_addr;
    assign w_op_wd   = (r_state == IDLE) ? bus.w_req_wd   : r_wd;
    assign w_op_be   = (r_state == IDLE) ? bus.w_req_be   : r_be;

    assign w_op_err = (w_op_addr[1:0] != 2'b00) || ({2'b00, w_op_addr[31:2]} >= DEPTH_W);
    assign w_op_idx = w_op_addr[IDX_W+1:2];

    // State register and wait counter
    always_ff @(posedge w_clock) begin
        if (!w_rst_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && (LATENCY != 0)) begin
                r_wait_cnt <= WAIT_LOAD;
            end else if ((r_state == WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.w_req_valid) begin
                    w_state_nxt = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.w_rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.w_req_ready = (r_state == IDLE);
        bus.w_rsp_valid = (r_state == RESP);
    end

    assign bus.w_rsp_rd  = r_rsp_rd;
    assign bus.w_rsp_err = r_rsp_err;
    assign w_ncomp       = r_ncomp;

    // Request capture: data only, no reset needed
    always_ff @(posedge w_clock) begin
        if (w_accept) begin
            r_we   <= bus.w_req_we;
            r_addr <= bus.w_req_addr;
            r_wd   <= bus.w_req_wd;
            r_be   <= bus.w_req_be;
        end
    end

    // Response registers and completion counter
    always_ff @(posedge w_clock) begin
        if (!w_rst_n) begin
            r_rsp_rd  <= 32'h0;
            r_rsp_err <= 1'b0;
            r_ncomp   <= 32'h0;
        end else begin
            if (w_enter_resp) begin
                r_rsp_err <= w_op_err;
                r_rsp_rd  <= (w_op_we || w_op_err) ? 32'h0 : r_mem[w_op_idx];
            end
            if (w_rsp_hs) begin
                r_ncomp <= r_ncomp + 32'd1;
            end
        end
    end

    // Memory write: reset on the same edge wins, so an abandoned store is dropped
    always_ff @(posedge w_clock) begin
        if (w_rst_n && w_enter_resp && w_op_we && !w_op_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_op_be[k]) begin
                    r_mem[w_op_idx][8*k +: 8] <= w_op_wd[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_m_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_m_dmem_responder
// Directed bench for m_dmem_responder: one instance with LATENCY=2 (index 0)
// and one with LATENCY=0 (index 1), sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_m_dmem_responder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    m_dmem_responder_if if_l2 ();
    m_dmem_responder_if if_l0 ();

    logic [31:0] ncomp_l2;
    logic [31:0] ncomp_l0;

    m_dmem_responder #(.LATENCY(2), .DEPTH(64)) u_dut_l2 (
        .w_clock (clk),
        .w_rst_n (rst_n),
        .bus     (if_l2),
        .w_ncomp (ncomp_l2)
    );

    m_dmem_responder #(.LATENCY(0), .DEPTH(64)) u_dut_l0 (
        .w_clock (clk),
        .w_rst_n (rst_n),
        .bus     (if_l0),
        .w_ncomp (ncomp_l0)
    );

    // Per-instance drive and observe arrays so one task serves both DUTs
    logic        v_valid     [2];
    logic        v_we        [2];
    logic [31:0] v_addr      [2];
    logic [31:0] v_wd        [2];
    logic [3:0]  v_be        [2];
    logic        v_rsp_ready [2];

    logic        o_ready [2];
    logic        o_valid [2];
    logic [31:0] o_rd    [2];
    logic        o_err   [2];
    logic [31:0] o_ncomp [2];

    assign if_l2.w_req_valid = v_valid[0];
    assign if_l2.w_req_we    = v_we[0];
    assign if_l2.w_req_addr  = v_addr[0];
    assign if_l2.w_req_wd    = v_wd[0];
    assign if_l2.w_req_be    = v_be[0];
    assign if_l2.w_rsp_ready = v_rsp_ready[0];
    assign if_l0.w_req_valid = v_valid[1];
    assign if_l0.w_req_we    = v_we[1];
    assign if_l0.w_req_addr  = v_addr[1];
    assign if_l0.w_req_wd    = v_wd[1];
    assign if_l0.w_req_be    = v_be[1];
    assign if_l0.w_rsp_ready = v_rsp_ready[1];

    assign o_ready[0] = if_l2.w_req_ready;
    assign o_valid[0] = if_l2.w_rsp_valid;
    assign o_rd[0]    = if_l2.w_rsp_rd;
    assign o_err[0]   = if_l2.w_rsp_err;
    assign o_ncomp[0] = ncomp_l2;
    assign o_ready[1] = if_l0.w_req_ready;
    assign o_valid[1] = if_l0.w_rsp_valid;
    assign o_rd[1]    = if_l0.w_rsp_rd;
    assign o_err[1]   = if_l0.w_rsp_err;
    assign o_ncomp[1] = ncomp_l0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request on instance d, check latency and response, optionally
    // hold off the response for 'hold' cycles, then complete the handshake.
    task automatic do_req(input int d, input string tag, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat, input int hold);
        int          lat;
        logic [31:0] nc_before;
        logic [31:0] rd_seen;
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(o_ready[d]), 32'd1);
        v_valid[d] = 1'b1;
        v_we[d]    = we;
        v_addr[d]  = addr;
        v_wd[d]    = wd;
        v_be[d]    = be;
        @(posedge clk);
        @(negedge clk);
        // Scramble the request inputs: the latched copy must be used
        v_valid[d] = 1'b0;
        v_we[d]    = ~we;
        v_addr[d]  = ~addr;
        v_wd[d]    = ~wd;
        v_be[d]    = ~be;
        lat = 0;
        while (!o_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".rsp_rd"}, o_rd[d], exp_rd);
        chk({tag, ".rsp_err"}, 32'(o_err[d]), 32'(exp_err));
        chk({tag, ".ready_in_resp"}, 32'(o_ready[d]), 32'd0);
        nc_before = o_ncomp[d];
        rd_seen   = o_rd[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(o_valid[d]), 32'd1);
            chk({tag, ".hold_rd"}, o_rd[d], rd_seen);
            chk({tag, ".hold_ready"}, 32'(o_ready[d]), 32'd0);
            chk({tag, ".hold_ncomp"}, o_ncomp[d], nc_before);
        end
        v_rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v_rsp_ready[d] = 1'b0;
        chk({tag, ".valid_after_hs"}, 32'(o_valid[d]), 32'd0);
        chk({tag, ".ready_after_hs"}, 32'(o_ready[d]), 32'd1);
        chk({tag, ".ncomp_inc"}, o_ncomp[d], nc_before + 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_bad;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            v_valid[d]     = 1'b0;
            v_we[d]        = 1'b0;
            v_addr[d]      = 32'h0;
            v_wd[d]        = 32'h0;
            v_be[d]        = 4'h0;
            v_rsp_ready[d] = 1'b0;
        end

        // Reset, with a store offered to instance 0 that must be ignored
        @(negedge clk);
        v_valid[0] = 1'b1;
        v_we[0]    = 1'b1;
        v_addr[0]  = 32'h30;
        v_wd[0]    = 32'hFFFF_FFFF;
        v_be[0]    = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("rst.ready_l2", 32'(o_ready[0]), 32'd1);
        chk("rst.valid_l2", 32'(o_valid[0]), 32'd0);
        chk("rst.rd_l2", o_rd[0], 32'h0);
        chk("rst.err_l2", 32'(o_err[0]), 32'd0);
        chk("rst.ncomp_l2", o_ncomp[0], 32'h0);
        chk("rst.ready_l0", 32'(o_ready[1]), 32'd1);
        chk("rst.ncomp_l0", o_ncomp[1], 32'h0);
        v_valid[0] = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        chk("post_rst.ready_l2", 32'(o_ready[0]), 32'd1);
        chk("post_rst.valid_l2", 32'(o_valid[0]), 32'd0);

        // Store / load with LATENCY=2
        do_req(0, "st_beef", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 2, 0);
        do_req(0, "ld_beef", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);
        chk("ncomp_after_2", o_ncomp[0], 32'd2);

        // Single byte lane, then an all-disabled store
        do_req(0, "st_lane0", 1'b1, 32'h10, 32'h0000_00AA, 4'h1, 32'h0, 1'b0, 2, 0);
        do_req(0, "ld_lane0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 2, 0);
        do_req(0, "st_be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 2, 0);
        do_req(0, "ld_be0", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEAA, 1'b0, 2, 0);
        chk("ncomp_after_6", o_ncomp[0], 32'd6);

        // Backpressure for 5 cycles
        do_req(0, "ld_bp", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 2, 5);

        // Error cases; aliased indices must not be written
        do_req(0, "ld_misal", 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, 2, 0);
        do_req(0, "st_oor", 1'b1, 32'h100, 32'h55, 4'hF, 32'h0, 1'b1, 2, 0);
        do_req(0, "ld_mem0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 2, 0);
        do_req(0, "st_misal", 1'b1, 32'h11, 32'h0, 4'hF, 32'h0, 1'b1, 2, 0);
        do_req(0, "ld_after_misal", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 2, 0);
        chk("ncomp_after_12", o_ncomp[0], 32'd12);

        // Reset one cycle after accepting a store (instance 0 is in WAIT)
        @(negedge clk);
        v_valid[0] = 1'b1;
        v_we[0]    = 1'b1;
        v_addr[0]  = 32'h20;
        v_wd[0]    = 32'h1234;
        v_be[0]    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        v_valid[0] = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("wait_rst.ready", 32'(o_ready[0]), 32'd1);
        chk("wait_rst.ncomp", o_ncomp[0], 32'd0);
        chk("wait_rst.rd_cleared", o_rd[0], 32'h0);
        idle_bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_valid[0] !== 1'b0) idle_bad++;
        end
        chk("wait_rst.no_response", 32'(idle_bad), 32'd0);
        do_req(0, "ld_abandoned", 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0, 2, 0);
        do_req(0, "ld_survives_rst", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, 2, 0);
        do_req(0, "ld_rst_ignored", 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 2, 0);
        chk("ncomp_after_wait_rst", o_ncomp[0], 32'd3);

        // LATENCY=0 instance
        do_req(1, "l0_st", 1'b1, 32'h3C, 32'h7, 4'hF, 32'h0, 1'b0, 0, 0);
        do_req(1, "l0_ld", 1'b0, 32'h3C, 32'h0, 4'h0, 32'h7, 1'b0, 0, 0);
        chk("l0_ncomp", o_ncomp[1], 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_dmem_responder.md
M_DMEM_RESPONDER -- requirements
Module: m_dmem_responder

Interface
REQ-001 The block SHALL take parameter LATENCY, default 2, giving the number of extra wait cycles between request acceptance and the response (legal range 0..15).
REQ-002 The block SHALL take parameter DEPTH, default 64, giving the number of 32-bit words, indexed by address bits [7:2].
REQ-003 w_clock  input  1  single clock; all state updates on its rising edge.
REQ-004 w_rst_n  input  1  reset, synchronous and active-low.
REQ-005 w_req_valid  input  1  initiator presents a request.
REQ-006 w_req_ready  output  1  block can accept a request this cycle.
REQ-007 w_req_we  input  1  1 = store, 0 = load.
REQ-008 w_req_addr  input  32  byte address.
REQ-009 w_req_wd  input  32  store data.
REQ-010 w_req_be  input  4  store byte enables; bit k selects bits [8k+7:8k].
REQ-011 w_rsp_valid  output  1  response available.
REQ-012 w_rsp_ready  input  1  initiator accepts the response.
REQ-013 w_rsp_rd  output  32  load data; 0 for stores and errors.
REQ-014 w_rsp_err  output  1  request was misaligned or out of range.
REQ-015 w_ncomp  output  32  count of completed response handshakes.

Function
REQ-016 The FSM SHALL have exactly 3 states: IDLE, WAIT and RESP.
REQ-017 w_req_ready SHALL be 1 exactly when the state is IDLE; w_rsp_valid SHALL be 1 exactly when the state is RESP.
REQ-018 A request SHALL be accepted on a rising edge where w_req_valid and w_req_ready are both 1.
REQ-019 On acceptance, we, addr, wd and be SHALL be latched; later changes on the request inputs SHALL have no effect.
REQ-020 On acceptance with LATENCY=0, the FSM SHALL go IDLE->RESP; otherwise it SHALL go IDLE->WAIT and load the wait counter with LATENCY-1.
REQ-021 In WAIT, the counter SHALL decrement each cycle; when it is 0, the FSM SHALL go WAIT->RESP.
REQ-022 For acceptance at edge N, w_rsp_valid SHALL first be 1 after edge N+LATENCY.
REQ-023 On the edge entering RESP, the block SHALL perform the memory access and register w_rsp_rd and w_rsp_err.
REQ-024 A load SHALL return mem[addr[7:2]] in full, ignoring be.
REQ-025 A store SHALL write only the enabled byte lanes; be=0 SHALL leave memory unchanged and still produce a normal response.
REQ-026 Error condition: addr[1:0]!=0, or addr[31:2] >= DEPTH.
REQ-027 On error, w_rsp_err SHALL be 1, w_rsp_rd SHALL be 0 and memory SHALL not be written.
REQ-028 In RESP, the FSM SHALL stay in RESP and hold w_rsp_rd and w_rsp_err stable while w_rsp_ready is 0.
REQ-029 In RESP with w_rsp_ready=1, the FSM SHALL go RESP->IDLE and increment w_ncomp (modulo 2^32, 0xFFFFFFFF wraps to 0).
REQ-030 No request SHALL be accepted in the same cycle as a response handshake; peak throughput SHALL be one request per LATENCY+2 cycles.
REQ-031 The block SHALL track at most 1 outstanding request.
REQ-032 Memory contents SHALL be initialised to 0 at time zero only.

Reset
REQ-033 When w_rst_n=0 at a rising edge, the block SHALL set: state=IDLE, wait counter=0, w_rsp_valid=0, w_rsp_rd=0, w_rsp_err=0, w_ncomp=0.
REQ-034 Reset SHALL take priority over every other event, including acceptance and response handshakes.
REQ-035 Reset during WAIT SHALL abandon the request, and a pending store SHALL not be written.
REQ-036 Reset SHALL NOT clear memory contents.
REQ-037 After reset, w_req_ready SHALL be 1 in the cycle following the first edge with w_rst_n=1, and SHALL remain 1 while w_rst_n=0.

Verification
REQ-038 Store/load, LATENCY=2: store addr 0x10, wd 0xDEADBEEF, be 0xF; then load addr 0x10 -> w_rsp_valid rises 2 edges after each acceptance; load returns 0xDEADBEEF, err 0; w_ncomp=2.
REQ-039 Byte lanes: after REQ-038, store addr 0x10, wd 0x000000AA, be 0x1; then load -> 0xDEADBEAA.
REQ-040 Backpressure: hold w_rsp_ready=0 for 5 cycles in RESP -> w_rsp_valid and w_rsp_rd stay stable, w_req_ready=0 throughout, w_ncomp is unchanged until the handshake.
REQ-041 Errors: load addr 0x12 -> err 1, rd 0; store addr 0x100, wd 0x55 -> err 1, mem[0] unchanged.
REQ-042 Reset in WAIT: store addr 0x20, wd 0x1234, assert w_rst_n=0 one cycle after acceptance -> no response, w_ncomp=0; a later load of 0x20 returns 0.
REQ-043 LATENCY=0: store then load addr 0x3C, wd 0x7 -> w_rsp_valid high in the cycle after each acceptance; the load returns 0x7.
